// File: rtl/uart_rx_oversampled_if.sv
// rtl/uart_rx_oversampled_if.sv - received-byte bundle between the UART receiver and its consumer
interface uart_rx_oversampled_if #(
    parameter int UART_BITS = 8
);
    logic [UART_BITS-1:0] o_rx_data;
    logic                 o_rx_done;
    logic                 o_frame_err;
    logic                 o_busy;

    modport master (
        output o_rx_data,
        output o_rx_done,
        output o_frame_err,
        output o_busy
    );

    modport slave (
        input o_rx_data,
        input o_rx_done,
        input o_frame_err,
        input o_busy
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receiver with start validation and stop framing check
module uart_rx_oversampled #(
    parameter int UART_BITS  = 8,
    parameter int TICK_DIV   = 163,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_TICKS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rx,
    uart_rx_oversampled_if.master  bus
);
    localparam int S_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
    localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int N_W   = (UART_BITS > 1) ? $clog2(UART_BITS) : 1;
    localparam int T_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(STOP_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(UART_BITS - 1);
    localparam logic [T_W-1:0] T_LAST = T_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic [T_W-1:0]       tick_cnt;
    logic                 rx_meta;
    logic                 rx_s;
    logic [S_W-1:0]       s_cnt;
    logic [N_W-1:0]       n_cnt;
    logic [UART_BITS-1:0] shift;
    logic                 tick;

    // Free-running; never realigned to the start edge, so sampling jitters by up to one tick.
    assign tick = (tick_cnt == T_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            tick_cnt        <= '0;
            rx_meta         <= 1'b1;
            rx_s            <= 1'b1;
            s_cnt           <= '0;
            n_cnt           <= '0;
            shift           <= '0;
            bus.o_rx_data   <= '0;
            bus.o_rx_done   <= 1'b0;
            bus.o_frame_err <= 1'b0;
            bus.o_busy      <= 1'b0;
        end else begin
            rx_meta         <= i_rx;
            rx_s            <= rx_meta;
            tick_cnt        <= tick ? '0 : tick_cnt + T_W'(1);
            bus.o_rx_done   <= 1'b0;
            bus.o_frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state      <= START;
                        s_cnt      <= '0;
                        bus.o_busy <= 1'b1;
                    end
                end

                START: begin
                    if (tick) begin
                        if (s_cnt == S_MID) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s_cnt <= '0;
                                n_cnt <= '0;
                            end else begin
                                // Glitch shorter than half a bit: drop it silently.
                                state      <= IDLE;
                                bus.o_busy <= 1'b0;
                            end
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (s_cnt == S_BIT) begin
                            shift <= {rx_s, shift[UART_BITS-1:1]};
                            s_cnt <= '0;
                            if (n_cnt == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n_cnt <= n_cnt + N_W'(1);
                            end
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (s_cnt == S_STOP) begin
                            if (rx_s) begin
                                bus.o_rx_data <= shift;
                                bus.o_rx_done <= 1'b1;
                            end else begin
                                bus.o_frame_err <= 1'b1;
                            end
                            state      <= IDLE;
                            bus.o_busy <= 1'b0;
                        end else begin
                            s_cnt <= s_cnt + S_W'(1);
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- Serial receiver feeding the debug controller's command path: converts the asynchronous `i_rx` line into bytes on `o_rx_data`.
- Each accepted byte is announced by a single-cycle `o_rx_done` pulse.
- Contains its own oversampling tick generator, input synchronizer, start-bit validation and stop-bit framing check.
- Sits between the board RX pin and the debug FSM.

Parameters:
- UART_BITS, 8, data bits per frame; LSB first, no parity.
- TICK_DIV, 163, clk cycles per oversample tick (50 MHz / (19200 baud × 16)).
- OVERSAMPLE, 16, ticks per bit period.
- STOP_TICKS, 16, ticks spent in the stop bit before it is sampled.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-low: block resets on the clk edge where rst == 0.
- i_rx  input  1  asynchronous serial line; idle high.
- o_rx_data  output  UART_BITS  last correctly framed byte.
- o_rx_done  output  1  one-clk pulse when o_rx_data is updated.
- o_frame_err  output  1  one-clk pulse when the stop bit is sampled low.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state = IDLE, tick counter = 0.
  - Both synchronizer flops = 1.
  - Shift register, sample counter and bit counter = 0.
  - o_rx_data = 0, o_rx_done = 0, o_frame_err = 0, o_busy = 0.
  - Reset in the middle of a frame discards the partial byte; no pulse is generated.
- Synchronizer:
  - Two flops on i_rx; all logic uses rx_s, the second-stage output.
  - Input-to-use latency is 2 clk.
- Tick generator:
  - Free-running counter over 0..TICK_DIV-1.
  - tick = 1 for one clk when the count equals TICK_DIV-1, then the count wraps to 0.
  - It is not realigned on the start edge, so ±1 tick of sampling jitter is accepted.
- Sample counter s_cnt (width clog2(max(OVERSAMPLE, STOP_TICKS))) and bit counter n_cnt (width clog2(UART_BITS)):
  - Both change only on tick cycles.
  - The sole exception is entry to START, which clears s_cnt without waiting for a tick.
- State machine IDLE / START / DATA / STOP:
  - IDLE: if rx_s == 0, go to START and set s_cnt = 0. Otherwise stay.
  - START, on tick:
    - If s_cnt == OVERSAMPLE/2 - 1 (mid start bit) and rx_s == 0: go to DATA, s_cnt = 0, n_cnt = 0.
    - If s_cnt == OVERSAMPLE/2 - 1 and rx_s == 1: false start; return to IDLE with no output activity.
    - Otherwise s_cnt++.
  - DATA, on tick:
    - If s_cnt == OVERSAMPLE-1: shift = {rx_s, shift[UART_BITS-1:1]} (LSB first) and s_cnt = 0.
      - If n_cnt == UART_BITS-1, go to STOP.
      - Otherwise n_cnt++.
    - Otherwise s_cnt++.
  - STOP, on tick:
    - If s_cnt == STOP_TICKS-1 and rx_s == 1: o_rx_data <= shift and o_rx_done = 1 for the next single clk.
    - If s_cnt == STOP_TICKS-1 and rx_s == 0: o_frame_err = 1 for a single clk; o_rx_data is unchanged and there is no done pulse.
    - In both cases go to IDLE.
    - Otherwise s_cnt++.
- Outputs:
  - o_rx_done and o_frame_err are never high at the same time.
  - Each is high for exactly 1 clk per frame, and goes high 1 clk after the stop-sampling tick.
  - o_rx_data holds its value until the next good frame; the consumer may sample it on the done cycle or at any later time.
- Back-to-back frames: a start bit that arrives right after STOP is sampled is detected from IDLE on the next clk, with no dead time beyond one cycle.
- A line held low (break condition) produces frame_err, then an immediate new start in IDLE. Break frames are not flagged separately.

Test Plan:
- TICK_DIV = 4, OVERSAMPLE = 16, bit period = 64 clk. Send 0xA5 as start, 10100101 LSB first, stop → exactly one o_rx_done pulse, o_rx_data = 0xA5, o_frame_err never high, o_busy high for about 10 bit periods.
- Send 0x00 then 0xFF back-to-back with no idle gap → two done pulses 640 ± 8 clk apart; o_rx_data = 0x00, then 0xFF.
- Drive an 8-clk (2-tick) low glitch on an idle line → START is entered, the check at mid start bit sees 1, FSM returns to IDLE; no done or frame_err pulse; o_rx_data keeps its previous value.
- Send 0x3C with the stop bit driven 0, after a prior good byte 0x11 → one o_frame_err pulse, no o_rx_done, o_rx_data stays 0x11.
- Assert rst = 0 for 1 clk partway through the data bits of 0x77, then send 0x5A cleanly → all outputs 0 right after reset; no pulse for the aborted frame; the next frame gives o_rx_data = 0x5A with one done pulse.
- Sweep the bit period ±3% (62 and 66 clk per bit) with byte 0xC3 → received correctly in both cases.
